// File: rtl/motor_pkg.sv
// Shared types and defaults for the motor step/direction datapath.
package motor_pkg;

   localparam int HALF_PERIOD_DEF = 1000;
   localparam int DIR_SETUP_DEF   = 50;
   localparam int POS_W           = 32;
   localparam int STEPS_W         = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DIR_SETUP,
      ST_STEP_HIGH,
      ST_STEP_LOW
   } state_t;

   // One step forward or backward; wraps modulo 2^POS_W.
   function automatic logic [POS_W-1:0] step_position(input logic [POS_W-1:0] pos,
                                                      input logic            fwd);
      return fwd ? pos + POS_W'(1) : pos - POS_W'(1);
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter shared by all timed FSM states.
// Loading L-1 on state entry makes expire_o assert on the L-th cycle of the state.
module phase_timer #(
   parameter int TIMER_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic [TIMER_W-1:0] load_val_i,
   output logic               expire_o
);

   logic [TIMER_W-1:0] count_q;

   // Reload on request, otherwise count down and park at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= load_val_i;
      end else if (count_q != '0) begin
         count_q <= count_q - TIMER_W'(1);
      end
   end

   assign expire_o = (count_q == '0);

endmodule

// File: rtl/stepper_step_gen.sv
// Per-axis STEP/DIR pulse generator with retargeting and signed position tracking.
module stepper_step_gen
   import motor_pkg::*;
#(
   parameter int HALF_PERIOD = HALF_PERIOD_DEF,
   parameter int DIR_SETUP   = DIR_SETUP_DEF,
   parameter int TIMER_W     = 16
) (
   input  logic               PCLK,
   input  logic               PRESERN,
   input  logic               load,
   input  logic [STEPS_W-1:0] steps_in,
   input  logic               dir_in,
   output logic               step,
   output logic               dir,
   output logic               busy,
   output logic               done,
   output logic [STEPS_W-1:0] remaining,
   output logic [POS_W-1:0]   position
);

   localparam logic [TIMER_W-1:0] HALF_LOAD  = TIMER_W'(HALF_PERIOD - 1);
   localparam logic [TIMER_W-1:0] SETUP_LOAD = TIMER_W'(DIR_SETUP - 1);

   state_t             state_q, state_d;
   logic               step_q, step_d;
   logic               dir_q, dir_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [STEPS_W-1:0] remaining_q, remaining_d;
   logic [POS_W-1:0]   position_q, position_d;
   logic               pend_valid_q, pend_valid_d;
   logic [STEPS_W-1:0] pend_steps_q, pend_steps_d;
   logic               pend_dir_q, pend_dir_d;

   logic               tmr_load;
   logic [TIMER_W-1:0] tmr_val;
   logic               tmr_expire;

   logic               start_cmd;
   logic [STEPS_W-1:0] cmd_steps;
   logic               cmd_dir;

   phase_timer #(
      .TIMER_W (TIMER_W)
   ) u_phase_timer (
      .clk        (PCLK),
      .rst_n      (PRESERN),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .expire_o   (tmr_expire)
   );

   // Next-state decision: phase sequencing, retargeting and the pending command.
   always_comb begin
      // NOTE: every variable gets a default first, so no path leaves one unassigned and infers a latch.
      state_d      = state_q;
      step_d       = step_q;
      dir_d        = dir_q;
      busy_d       = busy_q;
      done_d       = done_q;
      remaining_d  = remaining_q;
      position_d   = position_q;
      pend_valid_d = pend_valid_q;
      pend_steps_d = pend_steps_q;
      pend_dir_d   = pend_dir_q;
      tmr_load     = 1'b0;
      tmr_val      = HALF_LOAD;
      start_cmd    = 1'b0;
      cmd_steps    = steps_in;
      cmd_dir      = dir_in;

      case (state_q)
         ST_IDLE: begin
            if (load) start_cmd = 1'b1;
         end

         ST_DIR_SETUP: begin
            if (load) begin
               start_cmd = 1'b1;
            end else if (tmr_expire) begin
               state_d  = ST_STEP_HIGH;
               step_d   = 1'b1;
               tmr_load = 1'b1;
               tmr_val  = HALF_LOAD;
            end
         end

         ST_STEP_HIGH: begin
            // A pulse in flight is never cut short; a new command waits here (last load wins).
            if (load) begin
               pend_valid_d = 1'b1;
               pend_steps_d = steps_in;
               pend_dir_d   = dir_in;
            end
            if (tmr_expire) begin
               step_d = 1'b0;
               if (remaining_q != '0) begin
                  remaining_d = remaining_q - STEPS_W'(1);
                  position_d  = step_position(position_q, dir_q);
               end
               if (pend_valid_d) begin
                  // Skip the low phase: the DIR_SETUP phase provides both setup and low time.
                  start_cmd = 1'b1;
                  cmd_steps = pend_steps_d;
                  cmd_dir   = pend_dir_d;
               end else begin
                  state_d  = ST_STEP_LOW;
                  tmr_load = 1'b1;
                  tmr_val  = HALF_LOAD;
               end
            end
         end

         ST_STEP_LOW: begin
            if (load) begin
               start_cmd = 1'b1;
            end else if (tmr_expire) begin
               if (remaining_q == '0) begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d  = ST_STEP_HIGH;
                  step_d   = 1'b1;
                  tmr_load = 1'b1;
                  tmr_val  = HALF_LOAD;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Start a command exactly as from IDLE; a zero count completes immediately.
      if (start_cmd) begin
         dir_d        = cmd_dir;
         step_d       = 1'b0;
         pend_valid_d = 1'b0;
         if (cmd_steps == '0) begin
            state_d     = ST_IDLE;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            remaining_d = '0;
         end else begin
            state_d     = ST_DIR_SETUP;
            busy_d      = 1'b1;
            done_d      = 1'b0;
            remaining_d = cmd_steps;
            tmr_load    = 1'b1;
            tmr_val     = SETUP_LOAD;
         end
      end
   end

   // FSM state and registered pin/status outputs; reset drops step at once.
   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
         state_q      <= ST_IDLE;
         step_q       <= 1'b0;
         dir_q        <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         remaining_q  <= '0;
         position_q   <= '0;
         pend_valid_q <= 1'b0;
         pend_steps_q <= '0;
         pend_dir_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         step_q       <= step_d;
         dir_q        <= dir_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         remaining_q  <= remaining_d;
         position_q   <= position_d;
         pend_valid_q <= pend_valid_d;
         pend_steps_q <= pend_steps_d;
         pend_dir_q   <= pend_dir_d;
      end
   end

   assign step      = step_q;
   assign dir       = dir_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign remaining = remaining_q;
   assign position  = position_q;

endmodule

// File: tb/tb_stepper_step_gen.sv
// Directed bench for stepper_step_gen with HALF_PERIOD=4, DIR_SETUP=2.
module tb_stepper_step_gen;

   logic        PCLK     = 1'b0;
   logic        PRESERN  = 1'b0;
   logic        load     = 1'b0;
   logic [31:0] steps_in = '0;
   logic        dir_in   = 1'b0;
   logic        step, dir, busy, done;
   logic [31:0] remaining, position;

   int   tests = 0;
   int   fails = 0;
   int   rises = 0;
   int   base  = 0;
   int   cyc   = 0;
   logic step_prev = 1'b0;

   stepper_step_gen #(
      .HALF_PERIOD (4),
      .DIR_SETUP   (2),
      .TIMER_W     (16)
   ) dut (
      .PCLK      (PCLK),
      .PRESERN   (PRESERN),
      .load      (load),
      .steps_in  (steps_in),
      .dir_in    (dir_in),
      .step      (step),
      .dir       (dir),
      .busy      (busy),
      .done      (done),
      .remaining (remaining),
      .position  (position)
   );

   always #5 PCLK = ~PCLK;

   // Count rising edges of step, sampled away from the active edge.
   always @(negedge PCLK) begin
      if (step && !step_prev) rises <= rises + 1;
      step_prev <= step;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge PCLK);
         #1;
      end
   endtask

   // One-cycle load strobe; returns one tick after the accepting edge.
   task automatic issue(input logic [31:0] s, input logic d);
      steps_in = s;
      dir_in   = d;
      load     = 1'b1;
      tick(1);
      load     = 1'b0;
   endtask

   // Bounded wait for done; an expired budget shows up as a latency mismatch.
   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 500) begin
         tick(1);
         n++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      #12;
      check("rst_step", step, 1'b0);
      check("rst_dir", dir, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_remaining", remaining, 32'd0);
      check("rst_position", position, 32'd0);
      PRESERN = 1'b1;
      tick(1);

      // 3 forward steps: rise 2 cycles after entry, 4 high / 4 low, done at +26
      base = rises;
      issue(32'd3, 1'b1);
      check("t1_busy", busy, 1'b1);
      check("t1_dir", dir, 1'b1);
      check("t1_remaining", remaining, 32'd3);
      check("t1_done_cleared", done, 1'b0);
      check("t1_step_setup0", step, 1'b0);
      tick(1);
      check("t1_step_setup1", step, 1'b0);
      tick(1);
      check("t1_first_rise", step, 1'b1);
      tick(3);
      check("t1_high_hold", step, 1'b1);
      tick(1);
      check("t1_first_fall", step, 1'b0);
      check("t1_rem_after1", remaining, 32'd2);
      check("t1_pos_after1", position, 32'd1);
      wait_done(cyc);
      check("t1_done_latency", 32'(6 + cyc), 32'd26);
      check("t1_rises", 32'(rises - base), 32'd3);
      check("t1_position", position, 32'd3);
      check("t1_remaining_end", remaining, 32'd0);
      check("t1_busy_end", busy, 1'b0);

      // 5 reverse steps from +3 ends at -2
      base = rises;
      issue(32'd5, 1'b0);
      check("t2_dir_before_rise", dir, 1'b0);
      check("t2_step_setup", step, 1'b0);
      check("t2_remaining", remaining, 32'd5);
      wait_done(cyc);
      check("t2_done_latency", 32'(cyc), 32'd42);
      check("t2_rises", 32'(rises - base), 32'd5);
      check("t2_position", position, 32'hFFFF_FFFE);

      // Reset asserted mid STEP_HIGH, then IDLE ignores inputs without load
      issue(32'd4, 1'b1);
      tick(3);
      check("t3_in_high", step, 1'b1);
      PRESERN = 1'b0;
      #1;
      check("t3_rst_step", step, 1'b0);
      check("t3_rst_busy", busy, 1'b0);
      check("t3_rst_position", position, 32'd0);
      check("t3_rst_remaining", remaining, 32'd0);
      check("t3_rst_dir", dir, 1'b1);
      #2;
      PRESERN = 1'b1;
      base = rises;
      steps_in = 32'd7;
      dir_in   = 1'b1;
      tick(12);
      check("t3_idle_rises", 32'(rises - base), 32'd0);
      check("t3_idle_busy", busy, 1'b0);
      check("t3_idle_done", done, 1'b0);

      // Zero-step load in IDLE: done next cycle, no pulse
      base = rises;
      issue(32'd0, 1'b0);
      check("t4_done", done, 1'b1);
      check("t4_busy", busy, 1'b0);
      check("t4_dir", dir, 1'b0);
      check("t4_remaining", remaining, 32'd0);
      tick(10);
      check("t4_rises", 32'(rises - base), 32'd0);
      check("t4_position", position, 32'd0);

      // Retarget during the first STEP_HIGH: pulse completes, then DIR_SETUP, 2 reverse
      base = rises;
      issue(32'd10, 1'b1);
      tick(2);
      check("t5_first_rise", step, 1'b1);
      tick(1);
      steps_in = 32'd2;
      dir_in   = 1'b0;
      load     = 1'b1;
      tick(1);
      load     = 1'b0;
      check("t5_high_kept", step, 1'b1);
      check("t5_dir_kept", dir, 1'b1);
      check("t5_rem_kept", remaining, 32'd10);
      tick(2);
      check("t5_fall", step, 1'b0);
      check("t5_pos_after1", position, 32'd1);
      check("t5_new_dir", dir, 1'b0);
      check("t5_new_rem", remaining, 32'd2);
      check("t5_busy", busy, 1'b1);
      tick(1);
      check("t5_setup_low", step, 1'b0);
      tick(1);
      check("t5_rise_after_setup", step, 1'b1);
      wait_done(cyc);
      check("t5_done_latency", 32'(cyc), 32'd16);
      check("t5_rises", 32'(rises - base), 32'd3);
      check("t5_position", position, 32'hFFFF_FFFF);
      check("t5_done", done, 1'b1);

      // Wrap at 0x7FFFFFFF, plus a load on the final STEP_LOW cycle
      force dut.position_q = 32'h7FFF_FFFF;
      tick(1);
      release dut.position_q;
      tick(1);
      check("t6_preload", position, 32'h7FFF_FFFF);
      base = rises;
      issue(32'd1, 1'b1);
      tick(9);
      steps_in = 32'd1;
      dir_in   = 1'b1;
      load     = 1'b1;
      tick(1);
      load     = 1'b0;
      check("t6_wrap", position, 32'h8000_0000);
      check("t6_last_low_done", done, 1'b0);
      check("t6_last_low_busy", busy, 1'b1);
      check("t6_last_low_rem", remaining, 32'd1);
      wait_done(cyc);
      check("t6_done_latency", 32'(cyc), 32'd10);
      check("t6_position", position, 32'h8000_0001);
      check("t6_rises", 32'(rises - base), 32'd2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
